// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RISC-V subset controller.
// Holds opcode/funct3 constants, ALU operation encodings, the controller
// state enum and the decoded instruction-class enum.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_LW_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_ALU_WB,
    S_BRANCH,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CLS_LOAD,
    CLS_STORE,
    CLS_RTYPE,
    CLS_BRANCH
  } iclass_e;

endpackage

// File: rtl/instr_classifier.sv
// Combinational instruction classifier.
// Ports:
//   opcode_i   - IR[6:0]
//   funct3_i   - IR[14:12]
//   funct7_5_i - IR[30]
//   cls_o      - instruction class (meaningful only when legal_o = 1)
//   legal_o    - 1 when the encoding belongs to the supported subset
module instr_classifier
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output iclass_e    cls_o,
  output logic       legal_o
);

  always_comb begin
    cls_o   = CLS_LOAD;
    legal_o = 1'b0;
    case (opcode_i)
      OP_LOAD: begin
        cls_o   = CLS_LOAD;
        legal_o = (funct3_i == F3_LW_SW);
      end
      OP_STORE: begin
        cls_o   = CLS_STORE;
        legal_o = (funct3_i == F3_LW_SW);
      end
      OP_RTYPE: begin
        cls_o = CLS_RTYPE;
        // Only add, sub, and, or are implemented.
        case ({funct7_5_i, funct3_i})
          {1'b0, F3_ADDSUB},
          {1'b1, F3_ADDSUB},
          {1'b0, F3_AND},
          {1'b0, F3_OR}:  legal_o = 1'b1;
          default:        legal_o = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        cls_o   = CLS_BRANCH;
        legal_o = (funct3_i == F3_BEQ);
      end
      default: begin
        cls_o   = CLS_LOAD;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencing controller for the RISC-V subset core
// (add, sub, and, or, lw, sw, beq) with a unified instruction/data memory.
// Ports:
//   clk, reset_n            - clock (rising edge), async active-low reset
//   opcode/funct3/funct7_5  - decoded IR fields, stable from DECODE on
//   is_zero                 - ALU zero flag (branch decision)
//   mem_ready               - memory completes the pending access this cycle
//   pc_write, pc_src        - PC load enable and source (0 = PC+4, 1 = target)
//   ir_write                - IR load enable
//   mem_read, mem_write     - memory requests; i_or_d selects PC/ALU address
//   reg_write, mem_to_reg   - register write-back enable and source
//   alu_src, alu_oper       - ALU B select and operation class
//   illegal                 - sticky trap flag
//   retired                 - retired-instruction count (wraps)
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             is_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_oper,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q;
  iclass_e          cls_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  iclass_e          cls_d;
  logic             legal_d;
  logic             retire;

  instr_classifier u_classifier (
    .opcode_i   (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .cls_o      (cls_d),
    .legal_o    (legal_d)
  );

  // An instruction retires on the edge leaving its last phase.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEM_WB, S_ALU_WB, S_BRANCH: retire = 1'b1;
      S_MEM_WR:                     retire = mem_ready;
      default:                      retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_LOAD;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      if (retire) retired_q <= retired_q + 1'b1;
      case (state_q)
        S_FETCH:    if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= cls_d;
          if (!legal_d) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            case (cls_d)
              CLS_LOAD, CLS_STORE: state_q <= S_MEM_ADDR;
              CLS_RTYPE:           state_q <= S_EXEC_R;
              CLS_BRANCH:          state_q <= S_BRANCH;
              default:             state_q <= S_TRAP;
            endcase
          end
        end
        S_MEM_ADDR: state_q <= (cls_q == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   if (mem_ready) state_q <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_q <= S_FETCH;
        S_EXEC_R:   state_q <= S_ALU_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH: state_q <= S_FETCH;
        S_TRAP:     state_q <= S_TRAP;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops any
  // in-flight request without waiting for a clock edge.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_oper   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_MEM_ADDR: alu_src = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        alu_src  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        alu_src   = 1'b1;
      end
      S_EXEC_R: alu_oper = ALU_FUNCT;
      S_ALU_WB: begin
        alu_oper  = ALU_FUNCT;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_oper = ALU_SUB;
        pc_src   = 1'b1;
        pc_write = is_zero;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a
// randomized instruction stream, checked every cycle against a phase-list
// model derived from the instruction class and memory wait counts.
module tb_multicycle_controller;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             is_zero;
  logic             mem_ready;
  logic             pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
  logic             reg_write, mem_to_reg, alu_src, illegal;
  logic [1:0]       alu_oper;
  logic [CNT_W-1:0] retired;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .is_zero    (is_zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_oper   (alu_oper),
    .illegal    (illegal),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_oper;
    logic       illegal;
  } vec_t;

  typedef enum int {K_LOAD, K_STORE, K_RTYPE, K_BRANCH, K_ILL} kind_e;

  vec_t             act;
  vec_t             exp_v;
  logic [CNT_W-1:0] exp_ret;
  string            phase;
  bit               chk_en;
  int               tests;
  int               fails;
  int               cyc_cnt;

  assign act = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                reg_write, mem_to_reg, alu_src, alu_oper, illegal};

  // Per-cycle comparison against the model expectation.
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL strobes t=%0t phase=%s actual=%b required=%b", $time, phase, act, exp_v);
      end
      tests++;
      if (retired !== exp_ret) begin
        fails++;
        $display("FAIL retired t=%0t phase=%s actual=%0d required=%0d", $time, phase, retired, exp_ret);
      end
      tests++;
      if (mem_read && mem_write) begin
        fails++;
        $display("FAIL rd_wr_exclusive t=%0t actual=11 required=not both", $time);
      end
      tests++;
      if (ir_write && reg_write) begin
        fails++;
        $display("FAIL ir_reg_exclusive t=%0t actual=11 required=not both", $time);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
    tests++;
    if (a !== r) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  function automatic kind_e classify(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    if (op == 7'b0000011 && f3 == 3'b010) return K_LOAD;
    if (op == 7'b0100011 && f3 == 3'b010) return K_STORE;
    if (op == 7'b1100011 && f3 == 3'b000) return K_BRANCH;
    if (op == 7'b0110011 &&
        ({f75, f3} == 4'b0000 || {f75, f3} == 4'b1000 ||
         {f75, f3} == 4'b0111 || {f75, f3} == 4'b0110)) return K_RTYPE;
    return K_ILL;
  endfunction

  // One clock cycle: present inputs and expectation, advance, update model.
  task automatic step(input vec_t e, input logic mr, input logic z, input bit rt, input string ph);
    mem_ready = mr;
    is_zero   = z;
    exp_v     = e;
    phase     = ph;
    @(posedge clk);
    if (rt) exp_ret = exp_ret + 1'b1;
    cyc_cnt++;
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick(input int v);
    return (v < 0) ? int'($urandom_range(0, 3)) : v;
  endfunction

  // Fetch + decode; leaves the DUT at the start of the first execute phase.
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic f75, input int fw);
    vec_t e;
    int nf;
    nf = pick(fw);
    opcode   = 7'($urandom);
    funct3   = 3'($urandom);
    funct7_5 = rbit();
    e = '0; e.mem_read = 1'b1;
    for (int i = 0; i < nf; i++) step(e, 1'b0, rbit(), 1'b0, "FETCH_WAIT");
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(e, 1'b1, rbit(), 1'b0, "FETCH");
    opcode = op; funct3 = f3; funct7_5 = f75;
    step('0, rbit(), rbit(), 1'b0, "DECODE");
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input int fw, input int mw, input int zsel, input int trap_cycles,
                           output int cycles);
    vec_t e;
    int start, nm;
    logic z;
    kind_e k;
    k = classify(op, f3, f75);
    start = cyc_cnt;
    fetch_decode(op, f3, f75, fw);
    nm = pick(mw);
    case (k)
      K_LOAD, K_STORE: begin
        e = '0; e.alu_src = 1'b1;
        step(e, rbit(), rbit(), 1'b0, "MEM_ADDR");
        e.i_or_d = 1'b1;
        if (k == K_LOAD) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        for (int i = 0; i < nm; i++) step(e, 1'b0, rbit(), 1'b0, "MEM_WAIT");
        if (k == K_LOAD) begin
          step(e, 1'b1, rbit(), 1'b0, "MEM_RD");
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          step(e, rbit(), rbit(), 1'b1, "MEM_WB");
        end else begin
          step(e, 1'b1, rbit(), 1'b1, "MEM_WR");
        end
      end
      K_RTYPE: begin
        e = '0; e.alu_oper = 2'b10;
        step(e, rbit(), rbit(), 1'b0, "EXEC_R");
        e.reg_write = 1'b1;
        step(e, rbit(), rbit(), 1'b1, "ALU_WB");
      end
      K_BRANCH: begin
        z = (zsel < 0) ? rbit() : 1'(zsel);
        e = '0; e.alu_oper = 2'b01; e.pc_src = 1'b1; e.pc_write = z;
        step(e, rbit(), z, 1'b1, "BRANCH");
      end
      default: begin
        e = '0; e.illegal = 1'b1;
        for (int i = 0; i < trap_cycles; i++) step(e, rbit(), rbit(), 1'b0, "TRAP");
      end
    endcase
    cycles = cyc_cnt - start;
  endtask

  task automatic do_reset();
    chk_en  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_ret = '0;
    chk_en  = 1'b1;
  endtask

  task automatic rand_legal(output logic [6:0] op, output logic [2:0] f3, output logic f75);
    f75 = rbit();
    case ($urandom_range(0, 3))
      0: begin op = 7'b0000011; f3 = 3'b010; end
      1: begin op = 7'b0100011; f3 = 3'b010; end
      2: begin op = 7'b1100011; f3 = 3'b000; end
      default: begin
        op = 7'b0110011;
        case ($urandom_range(0, 3))
          0: begin f75 = 1'b0; f3 = 3'b000; end
          1: begin f75 = 1'b1; f3 = 3'b000; end
          2: begin f75 = 1'b0; f3 = 3'b111; end
          default: begin f75 = 1'b0; f3 = 3'b110; end
        endcase
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vec_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic f75;
    tests = 0; fails = 0; cyc_cnt = 0;
    chk_en = 1'b0; exp_ret = '0; exp_v = '0; phase = "RESET";
    reset_n = 1'b0; mem_ready = 1'b0; is_zero = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;

    #1;
    check("reset_retired", 32'(retired), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_mem_write", 32'(mem_write), 32'd0);
    do_reset();

    // add, zero wait
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, -1, 20, cyc);
    check("add_latency", 32'(cyc), 32'd4);
    check("add_retired", 32'(retired), 32'd1);
    // lw with two wait states in MEM_RD
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 2, -1, 20, cyc);
    check("lw_latency", 32'(cyc), 32'd7);
    check("lw_retired", 32'(retired), 32'd2);
    // sw, zero wait
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, -1, 20, cyc);
    check("sw_latency", 32'(cyc), 32'd4);

    // beq taken then not taken from a fresh reset
    do_reset();
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, 20, cyc);
    check("beq_latency", 32'(cyc), 32'd3);
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 0, 20, cyc);
    check("beq2_retired", 32'(retired), 32'd2);

    // illegal encodings
    run_instr(7'b0010011, 3'($urandom), rbit(), 0, 0, -1, 20, cyc);
    check("trap_illegal", 32'(illegal), 32'd1);
    check("trap_retired", 32'(retired), 32'd2);
    do_reset();
    run_instr(7'b0110011, 3'b111, 1'b1, 0, 0, -1, 20, cyc);
    check("trap2_illegal", 32'(illegal), 32'd1);
    check("trap2_retired", 32'(retired), 32'd0);

    // reset asserted mid-store while mem_ready is low
    do_reset();
    run_instr(7'b0110011, 3'b110, 1'b0, 0, 0, -1, 20, cyc);
    fetch_decode(7'b0100011, 3'b010, 1'b0, 0);
    e = '0; e.alu_src = 1'b1;
    step(e, 1'b1, 1'b0, 1'b0, "MEM_ADDR");
    e.mem_write = 1'b1; e.i_or_d = 1'b1;
    step(e, 1'b0, 1'b0, 1'b0, "MEM_WR_WAIT");
    chk_en = 1'b0;
    check("midwr_mem_write_before", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midwr_mem_write_after", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_ret = '0;
    check("midwr_retired", 32'(retired), 32'd0);
    check("midwr_illegal", 32'(illegal), 32'd0);
    check("midwr_fetch", 32'({mem_read, i_or_d}), 32'b10);
    chk_en = 1'b1;

    // counter wrap
    for (int i = 1; i <= 16; i++) begin
      run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, -1, 20, cyc);
      if (i == 15) check("wrap_at_15", 32'(retired), 32'd15);
    end
    check("wrap_to_0", 32'(retired), 32'd0);
    check("wrap_illegal", 32'(illegal), 32'd0);

    // randomized stream with random wait states and occasional illegal ops
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        do begin
          op = 7'($urandom); f3 = 3'($urandom); f75 = rbit();
        end while (classify(op, f3, f75) != K_ILL);
        run_instr(op, f3, f75, -1, -1, -1, int'($urandom_range(1, 8)), cyc);
        do_reset();
      end else begin
        rand_legal(op, f3, f75);
        run_instr(op, f3, f75, -1, -1, -1, 20, cyc);
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM that turns the riscv subset core into a multi-cycle machine (add, sub, and, or, lw, sw, beq) sharing one unified instruction/data memory.
- Reads decoded fields from the datapath's instruction register and drives every datapath strobe and mux select, one phase per cycle.
- Stalls on a memory ready handshake, counts retired instructions, and traps on illegal encodings.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0], stable from DECODE until the next ir_write.
- funct3  in  3  IR[14:12].
- funct7_5  in  1  IR[30].
- is_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current mem_read/mem_write access this cycle.
- pc_write  out  1  PC load enable.
- pc_src  out  1  0 = PC+4, 1 = branch target (the datapath computes it from the PC latched with ir_write).
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back select: 1 = memory data.
- alu_src  out  1  ALU B operand: 0 = register, 1 = immediate.
- alu_oper  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- illegal  out  1  sticky trap flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Reset:
  - state = FETCH and the decoded class register clears.
  - illegal = 0 and retired = 0.
  - All strobes are combinational from state, so they deassert immediately on a reset assertion, including mid-access.
- The class register (LOAD, STORE, RTYPE, BRANCH) is written only in DECODE.
- FETCH
  - Drives mem_read=1, i_or_d=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE. Otherwise stay.
- DECODE
  - No strobes. The class is classified and latched here.
  - 0000011 with funct3=010 goes to MEM_ADDR as LOAD.
  - 0100011 with funct3=010 goes to MEM_ADDR as STORE.
  - 0110011 goes to EXEC_R as RTYPE for these {funct7_5, funct3} only: {0,000} add, {1,000} sub, {0,111} and, {0,110} or.
  - 1100011 with funct3=000 goes to BRANCH.
  - Anything else goes to TRAP.
- MEM_ADDR
  - Drives alu_src=1, alu_oper=00.
  - Goes to MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD
  - Drives mem_read=1, i_or_d=1, alu_src=1, alu_oper=00.
  - On mem_ready go to MEM_WB. Otherwise hold.
- MEM_WB
  - Drives reg_write=1, mem_to_reg=1, then goes to FETCH and retires.
- MEM_WR
  - Drives mem_write=1, i_or_d=1, alu_src=1, alu_oper=00.
  - On mem_ready go to FETCH and retire. Otherwise hold.
- EXEC_R
  - Drives alu_src=0, alu_oper=10, then goes to ALU_WB.
- ALU_WB
  - Drives alu_oper=10, reg_write=1, mem_to_reg=0, then goes to FETCH and retires.
- BRANCH
  - Drives alu_src=0, alu_oper=01, pc_src=1, pc_write=is_zero (same-cycle combinational).
  - Goes to FETCH and retires.
- TRAP
  - All strobes 0 and illegal=1. Terminal state; only reset leaves it.
  - retired does not count the illegal instruction.
- Retire means retired increments by 1 on the clock edge leaving MEM_WB, MEM_WR (with mem_ready), ALU_WB or BRANCH. It wraps from all-ones to 0.
- Latency with zero wait states (mem_ready held 1):
  - R-type 4 cycles, lw 5, sw 4, beq 3.
  - Each low-mem_ready cycle in FETCH, MEM_RD or MEM_WR adds exactly 1 cycle.
- Invariants:
  - mem_read and mem_write are never both 1.
  - At most one of ir_write and reg_write is 1 in any cycle.
  - Request strobes stay high and stable until mem_ready.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH.
  - Funct3 constants F3_ADDSUB, F3_AND, F3_OR, F3_LW_SW, F3_BEQ.
  - alu_oper encodings ALU_ADD, ALU_SUB, ALU_FUNCT.
  - State enum and instruction-class enum.
- One natural sub-module, instr_classifier: combinational opcode/funct3/funct7_5 to class plus legal. The FSM, counter and output decode stay in multicycle_controller.

Test Plan:
- add, zero-wait: opcode=0110011, f3=000, f7_5=0.
  - States FETCH, DECODE, EXEC_R, ALU_WB, FETCH.
  - reg_write=1 only in cycle 4 with alu_oper=10. retired goes 0 to 1 at the end of cycle 4.
- lw with mem_ready low for 2 cycles in MEM_RD.
  - 7 total cycles. mem_read=1 and i_or_d=1 held stable for 3 cycles.
  - MEM_WB has reg_write=1, mem_to_reg=1.
- beq twice, is_zero=1 then is_zero=0.
  - First: pc_write=1 with pc_src=1 in BRANCH.
  - Second: pc_write=0 in BRANCH.
  - Both retire, so retired=2 after 6 cycles.
- Illegal encodings (opcode=0010011; then R-type with f7_5=1, f3=111 after reset).
  - TRAP reached after DECODE, illegal=1 sticky for 20 cycles, all strobes 0, retired unchanged.
- reset_n asserted mid-MEM_WR (mem_write=1, mem_ready=0).
  - mem_write falls before the next clock edge.
  - After release: FETCH, retired=0, illegal=0.
- Counter wrap with CNT_W=4: run 16 add instructions.
  - retired goes 15 to 0 on the 16th retire, with no other side effects.
